prog_sequencer: RTL and testbench

- Run controller for the core's program counter and fetch path.
- Holds a small table of program start addresses written by the host.
- On a host request it loads the selected start address into the PC, enables the core, counts cycles until the core reports halt or a watchdog expires, then reports completion.
- Sits between the host/testbench interface and the prog_counter start/start_addr inputs.

---
 rtl/prog_sequencer.sv | 140 ++++++++++++++
 tb/tb_prog_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Run controller: launches a program from a host-written start-address table,
// enables the core until halt or watchdog, then reports completion.
//
// state  | meaning
// IDLE   | waiting for req
// LOAD   | pulse pc_start with the selected start address
// RUN    | core enabled, counting cycles until halt or watchdog
// DONE   | one-cycle completion pulse
module prog_sequencer #(
    parameter int          instr_width = 9,
    parameter int          idx_width   = 2,
    parameter int          cycle_width = 16,
    parameter int unsigned timeout     = 32'hFFFF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_we,
    input  logic [idx_width-1:0]   cfg_idx,
    input  logic [instr_width-1:0] cfg_addr,
    input  logic                   req,
    input  logic [idx_width-1:0]   req_idx,
    input  logic                   halt,
    output logic                   busy,
    output logic                   done,
    output logic                   timed_out,
    output logic [cycle_width-1:0] cycle_count,
    output logic                   pc_start,
    output logic [instr_width-1:0] pc_start_addr,
    output logic                   core_en
);

    localparam int                   DEPTH     = 2 ** idx_width;
    localparam logic [cycle_width-1:0] TIMEOUT_C = cycle_width'(timeout);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [idx_width-1:0]     idx_q, idx_d;
    logic [cycle_width-1:0]   cycle_count_q, cycle_count_d;
    logic                     timed_out_q, timed_out_d;
    logic [instr_width-1:0]   tbl_q [DEPTH];
    logic [instr_width-1:0]   tbl_d [DEPTH];
    logic [cycle_width-1:0]   cycle_inc;

    assign cycle_inc = cycle_count_q + cycle_width'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cycle_count_q <= '0;
            timed_out_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cycle_count_q <= cycle_count_d;
            timed_out_q   <= timed_out_d;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= tbl_d[i];
            end
        end
    end

    // Table writes are accepted in every state; LOAD reads tbl_q, so a write
    // landing on the IDLE->LOAD edge is visible, one issued during LOAD is not.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tbl_d[i] = tbl_q[i];
        end
        if (cfg_we) begin
            tbl_d[cfg_idx] = cfg_addr;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cycle_count_d = cycle_count_q;
        timed_out_d   = timed_out_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d   = req_idx;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cycle_count_d = '0;
                timed_out_d   = 1'b0;
                state_d       = S_RUN;
            end
            S_RUN: begin
                cycle_count_d = cycle_inc;
                // halt takes priority over a watchdog hit on the same cycle
                if (halt) begin
                    state_d = S_DONE;
                end else if (cycle_inc == TIMEOUT_C) begin
                    state_d     = S_DONE;
                    timed_out_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy          = 1'b1;
        done          = 1'b0;
        pc_start      = 1'b0;
        pc_start_addr = '0;
        core_en       = 1'b0;
        case (state_q)
            S_IDLE: busy = 1'b0;
            S_LOAD: begin
                pc_start      = 1'b1;
                pc_start_addr = tbl_q[idx_q];
            end
            S_RUN:  core_en = 1'b1;
            S_DONE: done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign timed_out   = timed_out_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: the driver pushes expected launch
// addresses and run results; a negedge monitor pops and compares.
module tb_prog_sequencer;

    localparam int IW = 9;
    localparam int XW = 2;
    localparam int CW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_we = 1'b0;
    logic [XW-1:0] cfg_idx = '0;
    logic [IW-1:0] cfg_addr = '0;
    logic          req = 1'b0;
    logic [XW-1:0] req_idx = '0;
    logic          halt = 1'b0;
    logic          busy, done, timed_out, pc_start, core_en;
    logic [CW-1:0] cycle_count;
    logic [IW-1:0] pc_start_addr;

    prog_sequencer #(
        .instr_width(IW),
        .idx_width  (XW),
        .cycle_width(CW),
        .timeout    (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_addr     (cfg_addr),
        .req          (req),
        .req_idx      (req_idx),
        .halt         (halt),
        .busy         (busy),
        .done         (done),
        .timed_out    (timed_out),
        .cycle_count  (cycle_count),
        .pc_start     (pc_start),
        .pc_start_addr(pc_start_addr),
        .core_en      (core_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit to;
    } done_t;

    logic [IW-1:0] exp_addr_q [$];
    done_t         exp_done_q [$];
    logic [IW-1:0] tbl [4];

    int vecs = 0;
    int errs = 0;
    int last_cnt = 0;
    bit last_to = 1'b0;
    int run_cnt = 0;
    bit prev_pc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_timed_out"}, timed_out, 0);
        check({tag, "_cycle_count"}, cycle_count, 0);
        check({tag, "_pc_start"}, pc_start, 0);
        check({tag, "_pc_start_addr"}, pc_start_addr, 0);
        check({tag, "_core_en"}, core_en, 0);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (reset) begin
            prev_pc = 1'b0;
            run_cnt = 0;
        end else begin
            done_t d;
            check("busy_decode", busy, {31'd0, pc_start | core_en | done});
            check("exclusive", ($countones({pc_start, core_en, done}) <= 1), 1);
            if (pc_start) begin
                check("pc_start_width", prev_pc, 0);
                if (exp_addr_q.size() == 0) check("unexpected_launch", 1, 0);
                else check("start_addr", pc_start_addr, exp_addr_q.pop_front());
                run_cnt = 0;
            end else begin
                check("addr_outside_load", pc_start_addr, 0);
            end
            if (core_en) begin
                check("run_count", cycle_count, run_cnt);
                run_cnt++;
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    d = exp_done_q.pop_front();
                    check("done_count", cycle_count, d.cnt);
                    check("done_timed_out", timed_out, d.to);
                    check("core_en_cycles", run_cnt, d.cnt);
                    last_cnt = d.cnt;
                    last_to  = d.to;
                end
            end
            if (!busy) begin
                check("hold_count", cycle_count, last_cnt);
                check("hold_timed_out", timed_out, last_to);
            end
            prev_pc = pc_start;
        end
    end

    // Called with the DUT in IDLE, just after a rising edge. Program halts on
    // its nth RUN cycle (never, if n > TO).
    task automatic launch(input int idx, input int n, input bit sw, input logic [IW-1:0] sa,
                          input bit lw, input logic [IW-1:0] la, input bit hold, input bit pulse);
        int    m;
        done_t d;
        cfg_we   = sw;
        cfg_idx  = XW'(idx);
        cfg_addr = sa;
        if (sw) tbl[idx] = sa;
        req     = 1'b1;
        req_idx = XW'(idx);
        halt    = 1'b0;
        exp_addr_q.push_back(tbl[idx]);
        m     = (n < TO) ? n : TO;
        d.cnt = m;
        d.to  = (n > TO);
        exp_done_q.push_back(d);
        @(posedge clk) #1;
        req      = 1'b0;
        req_idx  = XW'($urandom);
        cfg_we   = lw;
        cfg_addr = la;
        if (lw) tbl[idx] = la;
        halt = 1'($urandom % 2);
        for (int k = 1; k <= m; k++) begin
            @(posedge clk) #1;
            cfg_we = 1'b0;
            halt   = (k == n);
            req    = pulse && (k == 2);
        end
        @(posedge clk) #1;
        cfg_we = 1'b0;
        halt   = 1'($urandom % 2);
        req    = hold;
        @(posedge clk) #1;
        halt = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cfg_we = 1'($urandom % 2);
            cfg_idx = XW'($urandom);
            cfg_addr = IW'($urandom);
            if (cfg_we) tbl[cfg_idx] = cfg_addr;
            halt = 1'($urandom % 2);
            @(posedge clk) #1;
        end
        cfg_we = 1'b0;
        halt   = 1'b0;
    endtask

    task automatic reset_abort(input int idx);
        cfg_we  = 1'b0;
        req     = 1'b1;
        req_idx = XW'(idx);
        exp_addr_q.push_back(tbl[idx]);
        @(posedge clk) #1;
        req = 1'b0;
        repeat (3) @(posedge clk) #1;
        #2 reset = 1'b1;
        #1 check_all_zero("abort");
        exp_addr_q.delete();
        exp_done_q.delete();
        for (int i = 0; i < 4; i++) tbl[i] = '0;
        last_cnt = 0;
        last_to  = 1'b0;
        #4 reset = 1'b0;
        @(posedge clk) #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        bit prev_hold;
        bit h;
        for (int i = 0; i < 4; i++) tbl[i] = '0;
        #3 reset = 1'b1;
        #1 check_all_zero("reset");
        #10 reset = 1'b0;
        @(posedge clk) #1;
        launch(3, 4, 0, '0, 0, '0, 0, 0);
        idle_cycles(2);

        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_addr = 9'h040; tbl[1] = 9'h040;
        @(posedge clk) #1;
        cfg_we = 1'b0;
        launch(1, 5, 0, '0, 0, '0, 0, 0);
        idle_cycles(1);
        launch(0, 20, 0, '0, 0, '0, 0, 0);
        idle_cycles(1);
        launch(1, 8, 0, '0, 0, '0, 0, 0);
        idle_cycles(1);
        launch(2, 6, 0, '0, 0, '0, 0, 1);
        launch(1, 3, 0, '0, 0, '0, 1, 0);
        launch(1, 4, 0, '0, 0, '0, 0, 0);
        idle_cycles(1);
        launch(2, 5, 1, 9'h1FF, 1, 9'h010, 0, 0);
        idle_cycles(1);
        launch(2, 2, 0, '0, 0, '0, 0, 0);
        reset_abort(2);
        launch(2, 3, 0, '0, 0, '0, 0, 0);

        prev_hold = 1'b0;
        for (int r = 0; r < 40; r++) begin
            if (!prev_hold) idle_cycles($urandom_range(0, 3));
            h = (r != 39) && ($urandom % 4 == 0);
            launch($urandom_range(0, 3), $urandom_range(1, 11), 1'($urandom % 2), IW'($urandom),
                   1'($urandom % 2), IW'($urandom), h, 1'($urandom % 2));
            prev_hold = h;
        end
        idle_cycles(3);
        check("queues_drained", exp_addr_q.size() + exp_done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
